// File: rtl/exu_seq.sv
// exu_seq: iterative sequencer for the RV M-extension operations (MUL/DIV class).
// It accepts one operation over in_valid/in_ready and computes it one bit per
// cycle: shift-add multiply or restoring divide on operand magnitudes, with the
// sign applied at the end. It then holds the result on out_valid/out_ready
// until the consumer takes it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous abort; returns to IDLE on the next edge
//   in_valid/in_ready   operation handshake (in_ready = IDLE & ~flush)
//   in_op               funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   in_op1/in_op2       rs1/rs2 values
//   in_rd               destination tag, returned on out_rd
//   out_valid/out_ready result handshake
//   out_result/out_rd   result and its tag, held stable while in DONE
//   busy                high in CALC or DONE
//
// Build option: define EXU_SEQ_EARLY_ZERO_EN to make these operations finish
// on the fast path with a zero result: multiplies with a zero operand, and
// divides with a zero dividend and a nonzero divisor.
//
// state | meaning
// IDLE  | waiting for an operation
// CALC  | iterating, cnt_q counts down from W-1 to 0
// DONE  | result presented, waiting for out_ready
module exu_seq #(
  parameter int W     = 64,
  parameter int CNT_W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_op1,
  input  logic [W-1:0] in_op2,
  input  logic [4:0]   in_rd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [4:0]   out_rd,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

  logic [1:0]     state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [4:0]     rd_q, rd_d;
  logic           neg_q, neg_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   result_q, result_d;

  // Operand decode at accept time
  logic           in_div, s1_en, s2_en, sgn1, sgn2;
  logic [W-1:0]   mag1, mag2;
  logic           fast;
  logic [W-1:0]   fast_res;

  assign in_div = in_op[2];
  assign s1_en  = (in_op == 3'b001) | (in_op == 3'b010) |
                  (in_op == 3'b100) | (in_op == 3'b110);
  assign s2_en  = (in_op == 3'b001) | (in_op == 3'b100) | (in_op == 3'b110);
  assign sgn1   = s1_en & in_op1[W-1];
  assign sgn2   = s2_en & in_op2[W-1];
  assign mag1   = sgn1 ? -in_op1 : in_op1;
  assign mag2   = sgn2 ? -in_op2 : in_op2;

  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (in_div && in_op2 == '0) begin
      fast     = 1'b1;
      fast_res = in_op[1] ? in_op1 : '1;
    end else if (((in_op == 3'b100) || (in_op == 3'b110)) &&
                 in_op1 == INT_MIN && (&in_op2)) begin
      fast     = 1'b1;
      fast_res = in_op[1] ? '0 : in_op1;
    end
`ifdef EXU_SEQ_EARLY_ZERO_EN
    else if (!in_div && (in_op1 == '0 || in_op2 == '0)) begin
      fast     = 1'b1;
      fast_res = '0;
    end else if (in_div && in_op1 == '0) begin
      fast     = 1'b1;
      fast_res = '0;
    end
`endif
  end

  // One iteration. Multiply: acc = {partial, multiplier}, shifted right.
  // Divide: acc = {remainder, dividend/quotient}, shifted left.
  logic [W:0]     mul_sum, div_trial, div_diff;
  logic [2*W-1:0] acc_step, prod;
  logic [W-1:0]   quo, rem, fin_res;

  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + ({1'b0, opnd_q} & {(W+1){acc_q[0]}});
  assign div_trial = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff  = div_trial - {1'b0, opnd_q};

  always_comb begin
    if (op_q[2]) begin
      // Borrow out means the trial subtraction failed: restore.
      if (div_diff[W]) acc_step = {div_trial[W-1:0], acc_q[W-2:0], 1'b0};
      else             acc_step = {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[W-1:1]};
    end
  end

  // Negate the full 2W product before picking the half.
  assign prod = neg_q ? -acc_step : acc_step;
  assign quo  = acc_step[W-1:0];
  assign rem  = acc_step[2*W-1:W];

  always_comb begin
    if (op_q[2]) begin
      if (op_q[1]) fin_res = neg_q ? -rem : rem;
      else         fin_res = neg_q ? -quo : quo;
    end else begin
      fin_res = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d   = in_op;
            rd_d   = in_rd;
            // Remainder takes the dividend's sign; everything else the XOR.
            neg_d  = (in_div && in_op[1]) ? sgn1 : (sgn1 ^ sgn2);
            opnd_d = in_div ? mag2 : mag1;
            acc_d  = {{W{1'b0}}, (in_div ? mag1 : mag2)};
            cnt_d  = CNT_W'(W - 1);
            if (fast) begin
              result_d = fast_res;
              state_d  = S_DONE;
            end else begin
              state_d  = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            result_d = fin_res;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE) & ~flush;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_result = result_q;
  assign out_rd     = rd_q;

endmodule
